tile_pixel_walker: RTL and testbench

Downstream neighbour of the tile setup stage. Accepts one tile setup packet: tile origin, edge deltas, edge values at the origin, z plane gradients and color. It walks every pixel of the TILE_SIZE x TILE_SIZE tile in raster order and updates the three edge functions and z incrementally. Each covered pixel is emitted as a fragment to the depth/framebuffer stage through a valid/ready handshake.

---
 rtl/tile_pixel_walker_pkg.sv | 49 ++++
 rtl/tile_pixel_walker_edge_stepper.sv | 35 +++
 rtl/tile_pixel_walker.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_pixel_walker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pixel_walker_pkg.sv
// Shared types and constants for the tile pixel walker.
// Fixed-point layout is 12.4; edge functions and z are carried at twice
// the coordinate width so incremental sums have headroom and wrap silently.
package tile_pixel_walker_pkg;

  localparam int FX_TOTAL_BITS = 16;
  localparam int FX_FRAC_BITS  = 4;
  localparam int TILE_SIZE     = 32;
  localparam int NUM_VERTICES  = 3;

  localparam int EDGE_W = 2 * FX_TOTAL_BITS;
  localparam int PIX_W  = FX_TOTAL_BITS - FX_FRAC_BITS;
  localparam int IDX_W  = $clog2(TILE_SIZE);

  typedef struct packed {
    logic signed [FX_TOTAL_BITS-1:0] x;
    logic signed [FX_TOTAL_BITS-1:0] y;
    logic signed [FX_TOTAL_BITS-1:0] z;
  } coord_3d_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REJECT = 2'd2,
    DONE   = 2'd3
  } walker_state_t;

  // Sign-extend a coordinate-width value to the edge accumulator width.
  function automatic logic signed [EDGE_W-1:0] sext_fx(
    input logic signed [FX_TOTAL_BITS-1:0] v
  );
    return EDGE_W'(v);
  endfunction

  // Edge increment for one whole-pixel step: delta scaled into fixed point.
  function automatic logic signed [EDGE_W-1:0] pixel_step(
    input logic signed [FX_TOTAL_BITS-1:0] d
  );
    return sext_fx(d) <<< FX_FRAC_BITS;
  endfunction

  // Offset of the far tile corner: (TILE_SIZE-1) pixel steps.
  function automatic logic signed [EDGE_W-1:0] far_offset(
    input logic signed [EDGE_W-1:0] step
  );
    return (step <<< IDX_W) - step;
  endfunction

endpackage

// File: rtl/tile_pixel_walker_edge_stepper.sv
// Incremental evaluator for one plane equation (an edge function or z).
// Keeps the value at the start of the current row and the value at the
// current pixel; a y-step advances the row and restarts the pixel from it.
module tile_pixel_walker_edge_stepper
  import tile_pixel_walker_pkg::*;
(
  input  logic                     clk,
  input  logic                     load,
  input  logic                     step_x,
  input  logic                     step_y,
  input  logic signed [EDGE_W-1:0] init_val,
  input  logic signed [EDGE_W-1:0] x_step,
  input  logic signed [EDGE_W-1:0] y_step,
  output logic signed [EDGE_W-1:0] cur_val
);

  logic signed [EDGE_W-1:0] row_val;
  logic signed [EDGE_W-1:0] row_next;

  assign row_next = row_val + y_step;

  // Row-start and current value update: load wins, then row step, then pixel step
  always_ff @(posedge clk) begin
    if (load) begin
      row_val <= init_val;
      cur_val <= init_val;
    end else if (step_y) begin
      row_val <= row_next;
      cur_val <= row_next;
    end else if (step_x) begin
      cur_val <= cur_val + x_step;
    end
  end

endmodule

// File: rtl/tile_pixel_walker.sv
// Tile pixel walker: takes one tile setup packet, walks the tile in raster
// order one pixel per cycle, and emits covered pixels as fragments through
// a single-stage valid/ready output register.
// Optional macro EARLY_REJECT_EN adds a REJECT state after accept that
// discards tiles where one edge is negative at all four tile corners.
module tile_pixel_walker
  import tile_pixel_walker_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  output logic                     rdy_in,
  input  coord_3d_t                in_abs_pos,
  input  coord_3d_t                in_delta_0,
  input  coord_3d_t                in_delta_1,
  input  coord_3d_t                in_delta_2,
  input  logic signed [EDGE_W-1:0] in_edge_0,
  input  logic signed [EDGE_W-1:0] in_edge_1,
  input  logic signed [EDGE_W-1:0] in_edge_2,
  input  logic [3:0]               in_color,
  input  logic signed [FX_TOTAL_BITS-1:0] in_dzdx,
  input  logic signed [FX_TOTAL_BITS-1:0] in_dzdy,
  input  logic signed [EDGE_W-1:0] in_z_current,
  output logic                     vld_out,
  input  logic                     rdy_out,
  output logic [PIX_W-1:0]         frag_x,
  output logic [PIX_W-1:0]         frag_y,
  output logic signed [EDGE_W-1:0] frag_z,
  output logic [3:0]               frag_color,
  output logic                     tile_done
);

  walker_state_t state;
  walker_state_t state_next;

  logic                     accept;
  logic [IDX_W-1:0]         px_p0;
  logic [IDX_W-1:0]         py_p0;
  logic                     inside_p0;
  logic                     out_free;
  logic                     advance_p0;
  logic                     load_frag;
  logic                     row_end;
  logic                     last_px;
  logic                     step_x_en;
  logic                     step_y_en;

  logic [PIX_W-1:0]         base_x_q;
  logic [PIX_W-1:0]         base_y_q;
  logic [3:0]               color_q;

  coord_3d_t                delta_in  [NUM_VERTICES];
  logic signed [EDGE_W-1:0] edge_init [NUM_VERTICES];
  logic signed [EDGE_W-1:0] edge_sx_q [NUM_VERTICES];
  logic signed [EDGE_W-1:0] edge_sy_q [NUM_VERTICES];
  logic signed [EDGE_W-1:0] edge_cur  [NUM_VERTICES];
  logic signed [EDGE_W-1:0] z_sx_q;
  logic signed [EDGE_W-1:0] z_sy_q;
  logic signed [EDGE_W-1:0] z_cur;

  assign delta_in[0]  = in_delta_0;
  assign delta_in[1]  = in_delta_1;
  assign delta_in[2]  = in_delta_2;
  assign edge_init[0] = in_edge_0;
  assign edge_init[1] = in_edge_1;
  assign edge_init[2] = in_edge_2;

  // Packet latch: tile origin, colour and per-pixel increments
  always_ff @(posedge clk) begin
    if (accept) begin
      base_x_q <= in_abs_pos.x[FX_TOTAL_BITS-1:FX_FRAC_BITS];
      base_y_q <= in_abs_pos.y[FX_TOTAL_BITS-1:FX_FRAC_BITS];
      color_q  <= in_color;
      z_sx_q   <= sext_fx(in_dzdx);
      z_sy_q   <= sext_fx(in_dzdy);
      for (int i = 0; i < NUM_VERTICES; i++) begin
        // Moving along x changes an edge by its delta.y, along y by delta.x.
        edge_sx_q[i] <= pixel_step(delta_in[i].y);
        edge_sy_q[i] <= pixel_step(delta_in[i].x);
      end
    end
  end

  for (genvar g = 0; g < NUM_VERTICES; g++) begin : g_edge
    tile_pixel_walker_edge_stepper u_edge (
      .clk      (clk),
      .load     (accept),
      .step_x   (step_x_en),
      .step_y   (step_y_en),
      .init_val (edge_init[g]),
      .x_step   (edge_sx_q[g]),
      .y_step   (edge_sy_q[g]),
      .cur_val  (edge_cur[g])
    );
  end

  tile_pixel_walker_edge_stepper u_z (
    .clk      (clk),
    .load     (accept),
    .step_x   (step_x_en),
    .step_y   (step_y_en),
    .init_val (in_z_current),
    .x_step   (z_sx_q),
    .y_step   (z_sy_q),
    .cur_val  (z_cur)
  );

  // Stage p0: coverage test of the current pixel against all three edges
  always_comb begin
    inside_p0 = 1'b1;
    for (int i = 0; i < NUM_VERTICES; i++) begin
      inside_p0 = inside_p0 & ~edge_cur[i][EDGE_W-1];
    end
  end

  // An outside pixel never stalls; an inside one waits for a free output slot.
  assign out_free   = !vld_out || rdy_out;
  assign advance_p0 = (state == SCAN) && (!inside_p0 || out_free);
  assign load_frag  = (state == SCAN) && inside_p0 && out_free;
  assign row_end    = &px_p0;
  assign last_px    = row_end && (&py_p0);
  assign step_x_en  = advance_p0 && !row_end;
  assign step_y_en  = advance_p0 && row_end;

`ifdef EARLY_REJECT_EN
  logic signed [EDGE_W-1:0] corner_x  [NUM_VERTICES];
  logic signed [EDGE_W-1:0] corner_y  [NUM_VERTICES];
  logic signed [EDGE_W-1:0] corner_xy [NUM_VERTICES];
  logic                     reject_hit;

  // Corner test: current values still sit at the origin during REJECT
  always_comb begin
    reject_hit = 1'b0;
    for (int i = 0; i < NUM_VERTICES; i++) begin
      corner_x[i]  = edge_cur[i] + far_offset(edge_sx_q[i]);
      corner_y[i]  = edge_cur[i] + far_offset(edge_sy_q[i]);
      corner_xy[i] = corner_x[i] + far_offset(edge_sy_q[i]);
      reject_hit   = reject_hit | (edge_cur[i][EDGE_W-1] & corner_x[i][EDGE_W-1] &
                                   corner_y[i][EDGE_W-1] & corner_xy[i][EDGE_W-1]);
    end
  end
`endif

  // Pixel position counters, raster order
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      px_p0 <= '0;
      py_p0 <= '0;
    end else if (advance_p0) begin
      if (row_end) begin
        px_p0 <= '0;
        py_p0 <= py_p0 + 1'b1;
      end else begin
        px_p0 <= px_p0 + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef EARLY_REJECT_EN
          state_next = REJECT;
`else
          state_next = SCAN;
`endif
        end
      end
      REJECT: begin
`ifdef EARLY_REJECT_EN
        state_next = reject_hit ? DONE : SCAN;
`else
        state_next = IDLE;
`endif
      end
      SCAN: begin
        if (advance_p0 && last_px) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rdy_in    = (state == IDLE);
    tile_done = (state == DONE);
    accept    = vld_in && (state == IDLE);
  end

  // Stage p1: fragment output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out    <= 1'b0;
      frag_x     <= '0;
      frag_y     <= '0;
      frag_z     <= '0;
      frag_color <= '0;
    end else if (load_frag) begin
      vld_out    <= 1'b1;
      frag_x     <= base_x_q + PIX_W'(px_p0);
      frag_y     <= base_y_q + PIX_W'(py_p0);
      frag_z     <= z_cur;
      frag_color <= color_q;
    end else if (rdy_out) begin
      vld_out    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_pixel_walker.sv
// Directed testbench for tile_pixel_walker. Inputs are driven and outputs
// sampled on the falling clock edge; a fragment counts as transferred when
// vld_out && rdy_out is seen before a rising edge.
module tb_tile_pixel_walker;
  import tile_pixel_walker_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     vld_in;
  logic                     rdy_in;
  coord_3d_t                in_abs_pos;
  coord_3d_t                in_delta_0;
  coord_3d_t                in_delta_1;
  coord_3d_t                in_delta_2;
  logic signed [EDGE_W-1:0] in_edge_0;
  logic signed [EDGE_W-1:0] in_edge_1;
  logic signed [EDGE_W-1:0] in_edge_2;
  logic [3:0]               in_color;
  logic signed [FX_TOTAL_BITS-1:0] in_dzdx;
  logic signed [FX_TOTAL_BITS-1:0] in_dzdy;
  logic signed [EDGE_W-1:0] in_z_current;
  logic                     vld_out;
  logic                     rdy_out;
  logic [PIX_W-1:0]         frag_x;
  logic [PIX_W-1:0]         frag_y;
  logic signed [EDGE_W-1:0] frag_z;
  logic [3:0]               frag_color;
  logic                     tile_done;

  int checks = 0;
  int errors = 0;

  tile_pixel_walker dut (
    .clk          (clk),
    .rst          (rst),
    .vld_in       (vld_in),
    .rdy_in       (rdy_in),
    .in_abs_pos   (in_abs_pos),
    .in_delta_0   (in_delta_0),
    .in_delta_1   (in_delta_1),
    .in_delta_2   (in_delta_2),
    .in_edge_0    (in_edge_0),
    .in_edge_1    (in_edge_1),
    .in_edge_2    (in_edge_2),
    .in_color     (in_color),
    .in_dzdx      (in_dzdx),
    .in_dzdy      (in_dzdy),
    .in_z_current (in_z_current),
    .vld_out      (vld_out),
    .rdy_out      (rdy_out),
    .frag_x       (frag_x),
    .frag_y       (frag_y),
    .frag_z       (frag_z),
    .frag_color   (frag_color),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Packet with origin (ax,ay) pixels (plus a fractional part that must be
  // dropped), edge_0/delta_0.y as given, the other edges/deltas zero.
  task automatic set_packet(input int ax, input int ay,
                            input logic signed [31:0] e0, input logic signed [15:0] d0y,
                            input logic signed [15:0] dzdx, input logic signed [15:0] dzdy,
                            input logic signed [31:0] z0, input logic [3:0] color);
    in_abs_pos   = '0;
    in_abs_pos.x = 16'(ax * 16 + 7);
    in_abs_pos.y = 16'(ay * 16 + 3);
    in_delta_0   = '0;
    in_delta_0.y = d0y;
    in_delta_1   = '0;
    in_delta_2   = '0;
    in_edge_0    = e0;
    in_edge_1    = '0;
    in_edge_2    = '0;
    in_dzdx      = dzdx;
    in_dzdy      = dzdy;
    in_z_current = z0;
    in_color     = color;
  endtask

  // Offers the current packet; returns on the falling edge after acceptance.
  task automatic send_packet;
    int w;
    w = 0;
    vld_in = 1'b1;
    while (!rdy_in && w < 3000) begin
      tick();
      w++;
    end
    checks++;
    if (rdy_in !== 1'b1) begin
      errors++;
      $display("FAIL send_packet_ready: rdy_in=%0b required 1 within 3000 cycles", rdy_in);
    end
    tick();
    vld_in = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (rdy_in !== 1'b1) begin errors++; $display("FAIL reset_rdy_in: got %0b want 1", rdy_in); end
    checks++;
    if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld_out: got %0b want 0", vld_out); end
    checks++;
    if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_tile_done: got %0b want 0", tile_done); end
    checks++;
    if (frag_x !== '0 || frag_y !== '0 || frag_z !== '0 || frag_color !== '0) begin
      errors++;
      $display("FAIL reset_frag: got x=%0d y=%0d z=%0d c=%0d want all 0", frag_x, frag_y, frag_z, frag_color);
    end
  endtask

  task automatic test_full_tile;
    int n, bad, done_cnt, px, py;
    logic signed [31:0] z_6734;
    logic [PIX_W-1:0] fx0, fy0;
    logic signed [31:0] fz0;
    set_packet(64, 32, 0, 0, 16, 32, 0, 4'hA);
    rdy_out = 1'b1;
    send_packet();
    n = 0; bad = 0; done_cnt = 0; z_6734 = -1; fx0 = '1; fy0 = '1; fz0 = -1;
    for (int c = 0; c < 1200; c++) begin
      if (vld_out) begin
        px = n % 32; py = n / 32;
        if (n == 0) begin fx0 = frag_x; fy0 = frag_y; fz0 = frag_z; end
        if (frag_x == 12'd67 && frag_y == 12'd34) z_6734 = frag_z;
        if (frag_x !== 12'(64 + px) || frag_y !== 12'(32 + py) ||
            frag_z !== 32'(16 * px + 32 * py) || frag_color !== 4'hA) bad++;
        n++;
      end
      if (tile_done) done_cnt++;
      tick();
    end
    checks++;
    if (fx0 !== 12'd64 || fy0 !== 12'd32 || fz0 !== 0) begin
      errors++; $display("FAIL full_first_frag: got (%0d,%0d) z=%0d want (64,32) z=0", fx0, fy0, fz0);
    end
    checks++;
    if (z_6734 !== 112) begin errors++; $display("FAIL full_z_67_34: got %0d want 112", z_6734); end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL full_count: got %0d want 1024", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_sequence: %0d bad fragments, want 0", bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL full_tile_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_empty_tile;
    int n, done_at, want;
    set_packet(0, 0, -1, 0, 0, 0, 0, 4'h1);
    rdy_out = 1'b1;
    send_packet();
    n = 0; done_at = -1;
    // c counts rising edges since the accepting edge.
    for (int c = 1; c <= 1200; c++) begin
      if (vld_out) n++;
      if (tile_done && done_at < 0) done_at = c;
      tick();
    end
`ifdef EARLY_REJECT_EN
    want = 2;
`else
    // one SCAN cycle per pixel, tile_done shows in the DONE cycle after
    want = TILE_SIZE * TILE_SIZE + 1;
`endif
    checks++;
    if (n !== 0) begin errors++; $display("FAIL empty_count: got %0d fragments want 0", n); end
    checks++;
    if (done_at !== want) begin errors++; $display("FAIL empty_done_time: got %0d want %0d", done_at, want); end
  endtask

  task automatic test_partial_edge;
    int n, bad, done_cnt;
    set_packet(0, 0, -160, 1, 0, 0, 5, 4'h6);
    rdy_out = 1'b1;
    send_packet();
    n = 0; bad = 0; done_cnt = 0;
    for (int c = 0; c < 1200; c++) begin
      if (vld_out) begin
        if (frag_x !== 12'(10 + n % 22) || frag_y !== 12'(n / 22) ||
            frag_z !== 5 || frag_color !== 4'h6) bad++;
        n++;
      end
      if (tile_done) done_cnt++;
      tick();
    end
    checks++;
    if (n !== 704) begin errors++; $display("FAIL partial_count: got %0d want 704", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL partial_sequence: %0d bad fragments, want 0", bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL partial_tile_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_stall;
    int n, bad, unstable, stall_left, px, py;
    logic started;
    logic [PIX_W-1:0] sx, sy;
    logic signed [31:0] sz;
    set_packet(64, 32, 0, 0, 16, 32, 0, 4'hA);
    rdy_out = 1'b1;
    send_packet();
    n = 0; bad = 0; unstable = 0; stall_left = 0; started = 1'b0;
    sx = '0; sy = '0; sz = 0;
    for (int c = 0; c < 1300; c++) begin
      if (n == 5 && !started) begin
        started = 1'b1; stall_left = 10;
        sx = frag_x; sy = frag_y; sz = frag_z;
      end
      rdy_out = (stall_left == 0);
      if (stall_left > 0) begin
        if (!vld_out || frag_x !== sx || frag_y !== sy || frag_z !== sz) unstable++;
        stall_left--;
      end
      if (vld_out && rdy_out) begin
        px = n % 32; py = n / 32;
        if (frag_x !== 12'(64 + px) || frag_y !== 12'(32 + py) ||
            frag_z !== 32'(16 * px + 32 * py)) bad++;
        n++;
      end
      tick();
    end
    rdy_out = 1'b1;
    checks++;
    if (sx !== 12'd69 || sy !== 12'd32) begin
      errors++; $display("FAIL stall_held_frag: got (%0d,%0d) want (69,32)", sx, sy);
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, want 0", unstable); end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL stall_count: got %0d want 1024", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_sequence: %0d bad fragments, want 0", bad); end
  endtask

  task automatic test_mid_reset;
    int n, bad, done_cnt, px, py;
    set_packet(64, 32, 0, 0, 16, 32, 0, 4'h3);
    rdy_out = 1'b1;
    send_packet();
    n = 0;
    for (int c = 0; c < 1200 && n < 100; c++) begin
      if (vld_out) n++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (vld_out !== 1'b0) begin errors++; $display("FAIL midrst_vld_out: got %0b want 0", vld_out); end
    checks++;
    if (rdy_in !== 1'b1) begin errors++; $display("FAIL midrst_rdy_in: got %0b want 1", rdy_in); end
    checks++;
    if (frag_x !== '0 || frag_z !== '0) begin
      errors++; $display("FAIL midrst_frag: got x=%0d z=%0d want 0", frag_x, frag_z);
    end
    set_packet(0, 0, 0, 0, 1, 100, 7, 4'h4);
    send_packet();
    n = 0; bad = 0; done_cnt = 0;
    for (int c = 0; c < 1200; c++) begin
      if (vld_out) begin
        px = n % 32; py = n / 32;
        if (frag_x !== 12'(px) || frag_y !== 12'(py) ||
            frag_z !== 32'(7 + px + 100 * py) || frag_color !== 4'h4) bad++;
        n++;
      end
      if (tile_done) done_cnt++;
      tick();
    end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL midrst_count: got %0d want 1024", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midrst_sequence: %0d bad fragments, want 0", bad); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL midrst_tile_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    int n, bad, done_cnt, acc2, m, px, py, want_gap;
    set_packet(0, 0, 0, 0, 16, 32, 0, 4'h1);
    rdy_out = 1'b1;
    vld_in  = 1'b1;
    for (int w = 0; w < 50 && !rdy_in; w++) tick();
    tick();
    // Packet B is presented immediately with vld_in still high.
    set_packet(256, 128, 0, 0, -3, 7, 1000, 4'h2);
    n = 0; bad = 0; done_cnt = 0; acc2 = -1;
    for (int c = 1; c <= 2400; c++) begin
      if (vld_in && rdy_in && acc2 < 0) acc2 = c;
      if (vld_out) begin
        m = (n < 1024) ? n : n - 1024;
        px = m % 32; py = m / 32;
        if (n < 1024) begin
          if (frag_x !== 12'(px) || frag_y !== 12'(py) ||
              frag_z !== 32'(16 * px + 32 * py) || frag_color !== 4'h1) bad++;
        end else begin
          if (frag_x !== 12'(256 + px) || frag_y !== 12'(128 + py) ||
              frag_z !== 32'(1000 - 3 * px + 7 * py) || frag_color !== 4'h2) bad++;
        end
        n++;
      end
      if (tile_done) done_cnt++;
      tick();
      if (acc2 == c) vld_in = 1'b0;
    end
    vld_in = 1'b0;
`ifdef EARLY_REJECT_EN
    want_gap = TILE_SIZE * TILE_SIZE + 3;
`else
    want_gap = TILE_SIZE * TILE_SIZE + 2;
`endif
    checks++;
    if (acc2 !== want_gap) begin errors++; $display("FAIL b2b_accept_gap: got %0d want %0d", acc2, want_gap); end
    checks++;
    if (n !== 2048) begin errors++; $display("FAIL b2b_count: got %0d want 2048", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_sequence: %0d bad fragments, want 0", bad); end
    checks++;
    if (done_cnt !== 2) begin errors++; $display("FAIL b2b_tile_done: got %0d want 2", done_cnt); end
  endtask

  initial begin
    rst     = 1'b1;
    vld_in  = 1'b0;
    rdy_out = 1'b1;
    set_packet(0, 0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_full_tile();
    test_empty_tile();
    test_partial_edge();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
